// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types, baud-derived defaults and width helper for the UART TX arbiter
package uart_arb_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;
  localparam int CLK_HZ        = 50_000_000;
  localparam int BAUD          = 115200;
  localparam int BITS_PER_BYTE = 10;
  localparam int BYTE_CLKS_DEF = (CLK_HZ / BAUD) * BITS_PER_BYTE;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: producer request bus plus the transmitter-facing strobes of the arbiter
interface uart_tx_arbiter_if import uart_arb_pkg::*; #(parameter int NUM_REQ = 4) ();
  localparam int GW = clog2_min1(NUM_REQ);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           uart_tx_data;
  logic                 uart_tx_enable;
  logic                 busy;
  logic [GW-1:0]        grant_idx;
  modport master (output req_valid, req_data, input req_ready, uart_tx_data, uart_tx_enable, busy, grant_idx);
  modport slave (input req_valid, req_data, output req_ready, uart_tx_data, uart_tx_enable, busy, grant_idx);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above ptr_i, wrapping to 0
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         any_o,
  output logic [W-1:0] idx_o
);
  assign any_o = |req_i;
  always_comb begin
    logic [W-1:0] k;
    k = '0;
    idx_o = '0;
    // scan offsets downward so the smallest offset from the pointer wins
    for (int i = N - 1; i >= 0; i--) begin
      k = W'((int'(ptr_i) + i) % N);
      if (req_i[k]) idx_o = k;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter, paced by a fixed per-byte clock budget
module uart_tx_arbiter import uart_arb_pkg::*; #(
  parameter int NUM_REQ     = 4,
  parameter int BYTE_CLKS   = BYTE_CLKS_DEF,
  parameter int ENABLE_CLKS = 1
) (
  input logic clk_50m,
  input logic reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = clog2_min1(NUM_REQ);
  localparam int CW = clog2_min1(BYTE_CLKS);
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [GW-1:0]        ptr_q, ptr_d, gidx_q, gidx_d, win;
  logic [NUM_REQ-1:0]   ready_q, ready_d;
  logic [7:0]           data_q, data_d;
  logic                 en_q, en_d, busy_q, busy_d, any, grant, send_done, wait_done;
  rr_pick #(.N(NUM_REQ), .W(GW)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .any_o (any),
    .idx_o (win)
  );
  assign send_done = cnt_q == CW'(ENABLE_CLKS - 1);
  assign wait_done = cnt_q == CW'(BYTE_CLKS - 1);
  assign grant     = state_q == IDLE && any;
  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      ready_q <= '0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (any ? SEND : IDLE) :
              (state_q == SEND) ? (send_done ? WAIT : SEND) :
              (wait_done ? IDLE : WAIT);
  end
  // the counter keeps running from SEND entry through WAIT, so one compare closes the byte slot
  always_comb begin
    ready_d      = '0;
    ready_d[win] = grant;
    data_d       = grant ? bus.req_data[{win, 3'b000} +: 8] : data_q;
    gidx_d       = grant ? win : gidx_q;
    ptr_d        = grant ? ((win == GW'(NUM_REQ - 1)) ? '0 : win + 1'b1) : ptr_q;
    cnt_d        = grant ? '0 : (state_q == IDLE) ? cnt_q : cnt_q + 1'b1;
    en_d         = state_d == SEND;
    busy_d       = state_d != IDLE;
  end
  assign bus.req_ready      = ready_q;
  assign bus.uart_tx_data   = data_q;
  assign bus.uart_tx_enable = en_q;
  assign bus.busy           = busy_q;
  assign bus.grant_idx      = gidx_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of grant order, pacing, reset and dropped requests
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int BC = 20;
  localparam int EC = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter #(.NUM_REQ(N), .BYTE_CLKS(BC), .ENABLE_CLKS(EC)) dut (
    .clk_50m (clk),
    .reset   (rst),
    .bus     (bus)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_grant(output int t, output logic [7:0] d, output logic [1:0] g);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.uart_tx_enable && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("grant_timeout", n < 200, 1);
    t = cyc;
    d = bus.uart_tx_data;
    g = bus.grant_idx;
  endtask
  initial begin
    int n, t, tp;
    logic saw;
    logic [7:0] d;
    logic [1:0] g;
    logic [7:0] exp_d [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h13};
    logic [1:0] exp_g [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3};
    bus.req_valid = '0;
    bus.req_data  = '0;
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_data", bus.uart_tx_data, 8'h00);
    chk("rst_enable", bus.uart_tx_enable, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant", bus.grant_idx, 0);
    @(negedge clk) rst = 1'b0;
    saw = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.uart_tx_enable || bus.busy) saw = 1'b1;
    end
    chk("idle_quiet", saw, 0);
    chk("idle_data", bus.uart_tx_data, 8'h00);
    bus.req_data  = 32'h00A5_0000;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", bus.req_ready, 4'b0100);
    chk("single_data", bus.uart_tx_data, 8'hA5);
    chk("single_enable", bus.uart_tx_enable, 1);
    chk("single_busy", bus.busy, 1);
    chk("single_grant", bus.grant_idx, 2);
    bus.req_valid = '0;
    n = 1;
    saw = 1'b0;
    @(negedge clk);
    chk("single_ready_pulse", bus.req_ready, 0);
    chk("single_enable_pulse", bus.uart_tx_enable, 0);
    while (bus.busy && n < 100) begin
      n++;
      if (bus.uart_tx_enable) saw = 1'b1;
      @(negedge clk);
    end
    chk("single_busy_len", n, BC);
    chk("single_no_reenable", saw, 0);
    chk("single_data_hold", bus.uart_tx_data, 8'hA5);
    bus.req_data  = 32'h1312_1110;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("wrap_from3_grant", bus.grant_idx, 0);
    chk("wrap_from3_data", bus.uart_tx_data, 8'h10);
    bus.req_valid = '0;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_enable", bus.uart_tx_enable, 0);
    chk("midrst_data", bus.uart_tx_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("postrst_grant", bus.grant_idx, 1);
    chk("postrst_ready", bus.req_ready, 4'b0010);
    chk("postrst_data", bus.uart_tx_data, 8'h11);
    bus.req_valid = '0;
    repeat (5) @(negedge clk);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    bus.req_valid = '0;
    saw = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.req_ready[1] || bus.uart_tx_enable) saw = 1'b1;
    end
    chk("dropped_req_lost", saw, 0);
    chk("dropped_idle", bus.busy, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    tp = 0;
    for (int i = 0; i < 6; i++) begin
      wait_grant(t, d, g);
      chk($sformatf("rr_data%0d", i), d, exp_d[i]);
      chk($sformatf("rr_grant%0d", i), g, exp_g[i]);
      if (i > 0) chk($sformatf("rr_period%0d", i), t - tp, BC + 1);
      tp = t;
      if (i == 3) bus.req_valid = 4'b1001;
    end
    bus.req_valid = '0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
